// File: rtl/match_referee.sv
// Round and match referee for a two-player fighting game: sequences rounds, gates
// player actions and scores the match. Define MATCH_REFEREE_TIMER_EN to build the round timer.
module match_referee #(
   parameter int unsigned ROUND_TICKS   = 60,
   parameter int unsigned ROUNDS_TO_WIN = 2
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic       turn_valid,
   input  logic [2:0] action1_in,
   input  logic [2:0] action2_in,
   input  logic [1:0] health1,
   input  logic [1:0] health2,
   output logic [2:0] action1_out,
   output logic [2:0] action2_out,
   output logic       round_reset,
   output logic       fight_active,
   output logic [1:0] wins1,
   output logic [1:0] wins2,
   output logic [2:0] round_num,
   output logic [7:0] timer,
   output logic [1:0] winner,
   output logic       match_over
);

   typedef enum logic [2:0] {
      IDLE,
      ROUND_INIT,
      FIGHT,
      ROUND_END,
      MATCH_OVER
   } state_t;

   typedef enum logic [1:0] {
      SIDE_NONE = 2'b00,
      SIDE_P1   = 2'b01,
      SIDE_P2   = 2'b10,
      SIDE_DRAW = 2'b11
   } side_t;

   localparam logic [2:0] ACT_AWAIT  = 3'b010;
   localparam logic [1:0] WIN_TARGET = 2'(ROUNDS_TO_WIN);
   localparam logic [1:0] WINS_MAX   = 2'd3;
   localparam logic [2:0] ROUND_MAX  = 3'd7;

   state_t     state;
   state_t     next_state;
   side_t      round_result;
   logic       ko;
   logic       timeout;
   logic       round_done;
   logic       match_done;
   logic       new_match;
   logic       last_round;

   logic       round_reset_nxt;
   logic       fight_active_nxt;
   logic       match_over_nxt;
   logic       last_round_nxt;
   logic [1:0] wins1_nxt;
   logic [1:0] wins2_nxt;
   logic [1:0] winner_nxt;
   logic [2:0] round_num_nxt;

   // Health only counts while fighting; timeout is already qualified by FIGHT.
   assign ko         = (state == FIGHT) && ((health1 == 2'b00) || (health2 == 2'b00));
   assign round_done = ko || timeout;
   assign match_done = (wins1 == WIN_TARGET) || (wins2 == WIN_TARGET) || last_round;
   assign new_match  = ((state == IDLE) || (state == MATCH_OVER)) && start;

   assign action1_out = fight_active ? action1_in : ACT_AWAIT;
   assign action2_out = fight_active ? action2_in : ACT_AWAIT;

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values regardless of process evaluation order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   // NOTE: every combinational output gets a default first, so no path leaves
   // a signal unassigned and no latch is inferred.
   always_comb begin
      next_state = state;
      unique case (state)
         IDLE:       if (start) next_state = ROUND_INIT;
         ROUND_INIT: next_state = FIGHT;
         FIGHT:      if (round_done) next_state = ROUND_END;
         ROUND_END:  next_state = match_done ? MATCH_OVER : ROUND_INIT;
         MATCH_OVER: if (start) next_state = ROUND_INIT;
         default:    next_state = IDLE;
      endcase
   end

   // A KO outranks a simultaneous timeout; on timeout the healthier side wins.
   always_comb begin
      round_result = SIDE_DRAW;
      if (ko) begin
         if ((health1 == 2'b00) && (health2 == 2'b00)) begin
            round_result = SIDE_DRAW;
         end else if (health1 == 2'b00) begin
            round_result = SIDE_P2;
         end else begin
            round_result = SIDE_P1;
         end
      end else if (health1 > health2) begin
         round_result = SIDE_P1;
      end else if (health2 > health1) begin
         round_result = SIDE_P2;
      end
   end

   // Registered outputs are computed from next_state, so they are valid in the
   // very cycle the FSM enters a state. Scores land on entry to ROUND_END, which
   // is why ROUND_END can already decide on the updated wins.
   always_comb begin
      round_reset_nxt  = (next_state == ROUND_INIT);
      fight_active_nxt = (next_state == FIGHT);
      match_over_nxt   = (next_state == MATCH_OVER);
      wins1_nxt        = wins1;
      wins2_nxt        = wins2;
      round_num_nxt    = round_num;
      winner_nxt       = winner;
      last_round_nxt   = last_round;

      if (new_match) begin
         wins1_nxt      = 2'd0;
         wins2_nxt      = 2'd0;
         round_num_nxt  = 3'd0;
         winner_nxt     = SIDE_NONE;
         last_round_nxt = 1'b0;
      end

      if ((state == FIGHT) && round_done) begin
         if ((round_result == SIDE_P1) && (wins1 != WINS_MAX)) wins1_nxt = wins1 + 2'd1;
         if ((round_result == SIDE_P2) && (wins2 != WINS_MAX)) wins2_nxt = wins2 + 2'd1;
         if (round_num != ROUND_MAX) round_num_nxt = round_num + 3'd1;
         last_round_nxt = (round_num == ROUND_MAX);
      end

      if ((state == ROUND_END) && match_done) begin
         if (wins1 > wins2) begin
            winner_nxt = SIDE_P1;
         end else if (wins2 > wins1) begin
            winner_nxt = SIDE_P2;
         end else begin
            winner_nxt = SIDE_DRAW;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         round_reset  <= 1'b0;
         fight_active <= 1'b0;
         match_over   <= 1'b0;
         wins1        <= 2'd0;
         wins2        <= 2'd0;
         round_num    <= 3'd0;
         winner       <= SIDE_NONE;
         last_round   <= 1'b0;
      end else begin
         round_reset  <= round_reset_nxt;
         fight_active <= fight_active_nxt;
         match_over   <= match_over_nxt;
         wins1        <= wins1_nxt;
         wins2        <= wins2_nxt;
         round_num    <= round_num_nxt;
         winner       <= winner_nxt;
         last_round   <= last_round_nxt;
      end
   end

`ifdef MATCH_REFEREE_TIMER_EN
   localparam logic [7:0] TICKS_LOAD = 8'(ROUND_TICKS);

   // The final turn of the round both expires the timer and leaves it at zero.
   assign timeout = (state == FIGHT) && turn_valid && (timer == 8'd1);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         timer <= 8'd0;
      end else if (next_state == ROUND_INIT) begin
         timer <= TICKS_LOAD;
      end else if ((state == FIGHT) && turn_valid && (timer != 8'd0)) begin
         timer <= timer - 8'd1;
      end
   end
`else
   logic unused_timer_cfg;

   assign timeout          = 1'b0;
   assign timer            = 8'd0;
   assign unused_timer_cfg = turn_valid ^ (ROUND_TICKS == 0);
`endif

endmodule

// File: doc/match_referee.md
MATCH_REFEREE -- requirements
Module: match_referee

Interface
REQ-001 SHALL have parameter ROUND_TICKS, default 60: turns per round before the timer expires (legal range 1..255).
REQ-002 SHALL have parameter ROUNDS_TO_WIN, default 2: round wins needed to take the match (legal range 1..3).
REQ-003 SHALL have port clk  in  1  single system clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  in  1  reset, asynchronous assert, active-low.
REQ-005 SHALL have port start  in  1  level; begins a match from IDLE or MATCH_OVER.
REQ-006 SHALL have port turn_valid  in  1  one-cycle pulse marking one game turn (actions are sampled by the players).
REQ-007 SHALL have ports action1_in, action2_in  in  3 each  raw player actions (kick 000, punch 001, await 010, jump 011, left 100/101, right 110/111).
REQ-008 SHALL have ports health1, health2  in  2 each  player health from the player modules; 2'b00 means KO.
REQ-009 SHALL have ports action1_out, action2_out  out  3 each  gated actions driven to the player modules.
REQ-010 SHALL have port round_reset  out  1  one-cycle pulse telling the players to restore health 2'b11 and their start states.
REQ-011 SHALL have port fight_active  out  1  high only in FIGHT.
REQ-012 SHALL have ports wins1, wins2  out  2 each; round_num  out  3; timer  out  8; winner  out  2 (00 none, 01 P1, 10 P2, 11 draw); match_over  out  1.

Function
REQ-013 SHALL implement FSM states IDLE, ROUND_INIT, FIGHT, ROUND_END, MATCH_OVER, with all outputs registered except the action gating.
REQ-014 SHALL go IDLE->ROUND_INIT when start=1, and MATCH_OVER->ROUND_INIT when start=1, clearing wins1, wins2, round_num and winner on that transition.
REQ-015 ROUND_INIT SHALL last exactly one cycle, assert round_reset, load timer=ROUND_TICKS, then go to FIGHT.
REQ-016 SHALL drive action_out=action_in combinationally when fight_active=1 and await (3'b010) otherwise.
REQ-017 In FIGHT, SHALL decrement timer by 1 on each turn_valid, and declare timeout when turn_valid=1 and timer==1 (timer reads 0 afterwards).
REQ-018 In FIGHT, SHALL end the round when health1==0 or health2==0; if a KO and a timeout occur in the same cycle, the KO takes priority.
REQ-019 On a KO, the player with non-zero health SHALL win the round; a double KO SHALL be a drawn round.
REQ-020 On a timeout, the player with higher health SHALL win the round; equal health SHALL be a drawn round.
REQ-021 ROUND_END SHALL last one cycle and perform these updates:
- increment the round winner's wins counter (saturating at 3);
- increment round_num (saturating at 7);
- go to MATCH_OVER if either wins counter equals ROUNDS_TO_WIN or round_num was 7, else go to ROUND_INIT.
REQ-022 On entry to MATCH_OVER, SHALL set winner to the side with more wins (11 if equal) and assert match_over until leaving MATCH_OVER.
REQ-023 SHALL ignore health inputs outside FIGHT, and SHALL ignore start outside IDLE and MATCH_OVER.

Reset
REQ-024 rst_n=0 SHALL immediately force IDLE and set:
- fight_active=0, round_reset=0, match_over=0;
- wins1=wins2=0, round_num=0, timer=0, winner=00.
REQ-025 Reset mid-round SHALL abort the round with no wins credited; the first round_reset after release SHALL occur only via start.

Configuration
REQ-026 With macro MATCH_REFEREE_TIMER_EN defined, the round timer (REQ-015, REQ-017, REQ-020) SHALL be present.
REQ-027 Without MATCH_REFEREE_TIMER_EN, the timer logic SHALL be absent: timer is held at 0, rounds end only by KO, and turn_valid is ignored.

Verification
REQ-028 Reset, start=1 for 1 cycle -> round_reset pulses exactly 1 cycle later; fight_active=1 the next cycle; timer=60.
REQ-029 In FIGHT, health2 driven to 0 -> the next cycle is ROUND_END with wins1=1, round_num=1; a second identical round -> match_over=1, winner=01.
REQ-030 With timer enabled and ROUND_TICKS=3: 3 turn_valid pulses with health1=2, health2=3 -> wins2 increments; with equal health -> no wins change, round_num increments.
REQ-031 In the same cycle, health1=health2=0 and the final turn_valid -> drawn round by KO, timer reads 0, no wins change.
REQ-032 action1_in=kick while in IDLE or ROUND_END -> action1_out=010; in FIGHT -> action1_out=000 in the same cycle.
REQ-033 rst_n low mid-FIGHT with wins1=1 -> all counters 0 and state IDLE immediately; after release with no start, fight_active stays 0.
